// File: rtl/oam_dma.sv
// ---------------------------------------------------------------------------
// oam_dma
//
// OAM DMA engine. A CPU write to FF46 (start_wr/start_data) launches a copy of
// XFER_LEN bytes from {src_hi, 8'h00} to DEST_BASE.. (FE00..FE9F by default),
// one byte per M-cycle. Each M-cycle reads the source during T-phases 0,1,
// latches the byte on the edge that samples phase 1, and writes it to the
// destination during phases 2,3. The transfer starts two M-cycle boundaries
// after the strobe (ARM aligns to a boundary, DELAY waits one more M-cycle).
//
// Optional feature (macro OAM_DMA_ECHO_MAP_EN): a written source byte >= E0
// has bit 5 cleared before capture, so E0..FF read from echo RAM C0..DF.
// With the macro undefined the written byte is used unchanged.
//
// Ports:
//   clk          system clock, one T-cycle per clock
//   rst          asynchronous active-high reset
//   t_cycle      T-phase 0..3; a posedge sampling 3 is the M-cycle boundary
//   start_wr     single-clock strobe: CPU wrote FF46
//   start_data   value written to FF46 (source high byte)
//   mem_data_in  external memory data output
//   dma_addr     DMA leg of the memory address mux
//   dma_data     byte latched for the write phase
//   dma_rd       DMA read request
//   dma_wr       DMA write enable
//   mem_ctrl_sel 1 = DMA owns the memory bus
//   busy         transfer pending or active
//   src_hi       FF46 readback (after optional echo mapping)
// ---------------------------------------------------------------------------
module oam_dma #(
  parameter int unsigned XFER_LEN  = 160,
  parameter logic [15:0] DEST_BASE = 16'hFE00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  t_cycle,
  input  logic        start_wr,
  input  logic [7:0]  start_data,
  input  logic [7:0]  mem_data_in,
  output logic [15:0] dma_addr,
  output logic [7:0]  dma_data,
  output logic        dma_rd,
  output logic        dma_wr,
  output logic        mem_ctrl_sel,
  output logic        busy,
  output logic [7:0]  src_hi
);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    DELAY,
    XFER
  } state_t;

  localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

  state_t     state;
  logic [7:0] idx;
  logic [7:0] src_mapped;
  logic       m_boundary;

  assign m_boundary = (t_cycle == 2'd3);

  // Source byte as it will be captured and read back.
  always_comb begin
`ifdef OAM_DMA_ECHO_MAP_EN
    src_mapped = (start_data >= 8'hE0) ? (start_data & 8'hDF) : start_data;
`else
    src_mapped = start_data;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= 8'h00;
      dma_data <= 8'h00;
      src_hi   <= 8'hFF;
    end else if (start_wr) begin
      // A restart from any state wins over completion or idx increment.
      state  <= ARM;
      idx    <= 8'h00;
      src_hi <= src_mapped;
    end else begin
      unique case (state)
        IDLE:  ;
        ARM:   if (m_boundary) state <= DELAY;
        DELAY: if (m_boundary) state <= XFER;
        XFER: begin
          if (t_cycle == 2'd1) dma_data <= mem_data_in;
          if (m_boundary) begin
            if (idx == LAST_IDX) state <= IDLE;
            else                 idx   <= idx + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output decode straight from registered state, so an asynchronous reset
  // releases the bus in the same instant.
  // NOTE: every output gets a default before the case logic, so no latch can
  // be inferred for paths that do not assign it.
  always_comb begin
    busy         = (state != IDLE);
    mem_ctrl_sel = (state == XFER);
    dma_rd       = 1'b0;
    dma_wr       = 1'b0;
    dma_addr     = 16'h0000;
    if (state == XFER) begin
      if (!t_cycle[1]) begin
        dma_addr = {src_hi, idx};
        dma_rd   = 1'b1;
      end else begin
        dma_addr = DEST_BASE + {8'h00, idx};
        dma_wr   = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_oam_dma.sv
// ---------------------------------------------------------------------------
// tb_oam_dma
//
// Self-checking bench for oam_dma. A 64 KiB random memory feeds mem_data_in;
// a monitor logs every destination write (address, byte) and counts busy and
// mem_ctrl_sel clocks. Expected write logs are built from the copy rule
// (dest FE00+i gets mem[{src,i}]) and expected busy lengths from the
// ARM/DELAY/XFER durations.
// ---------------------------------------------------------------------------
module tb_oam_dma;

  typedef struct packed {
    logic [15:0] a;
    logic [7:0]  d;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  t_cycle = 2'd0;
  logic        start_wr;
  logic [7:0]  start_data;
  logic [7:0]  mem_data_in;
  logic [15:0] dma_addr;
  logic [7:0]  dma_data;
  logic        dma_rd;
  logic        dma_wr;
  logic        mem_ctrl_sel;
  logic        busy;
  logic [7:0]  src_hi;

  logic [7:0]  mem [65536];
  wr_t         wr_q[$];
  wr_t         exp_q[$];
  int          busy_cnt;
  int          sel_cnt;
  int          n_cmp = 0;
  int          n_err = 0;

  oam_dma dut (
    .clk          (clk),
    .rst          (rst),
    .t_cycle      (t_cycle),
    .start_wr     (start_wr),
    .start_data   (start_data),
    .mem_data_in  (mem_data_in),
    .dma_addr     (dma_addr),
    .dma_data     (dma_data),
    .dma_rd       (dma_rd),
    .dma_wr       (dma_wr),
    .mem_ctrl_sel (mem_ctrl_sel),
    .busy         (busy),
    .src_hi       (src_hi)
  );

  always #5 clk = ~clk;

  // Free-running T-phase, as a registered decode would produce it.
  always @(posedge clk) t_cycle <= t_cycle + 2'd1;

  always_comb mem_data_in = mem[dma_addr];

  // Monitor, sampled 1 time unit after each active edge.
  always @(posedge clk) begin
    #1;
    if (busy === 1'b1)         busy_cnt++;
    if (mem_ctrl_sel === 1'b1) sel_cnt++;
    if (dma_wr === 1'b1 && t_cycle == 2'd2) begin
      wr_t e;
      e.a = dma_addr;
      e.d = dma_data;
      wr_q.push_back(e);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] map_src(input logic [7:0] d);
`ifdef OAM_DMA_ECHO_MAP_EN
    return (d >= 8'hE0) ? {d[7:6], 1'b0, d[4:0]} : d;
`else
    return d;
`endif
  endfunction

  function automatic int arm_len(input int k);
    return (k == 3) ? 4 : (3 - k);
  endfunction

  task automatic push_expected(input logic [7:0] src, input int n);
    for (int i = 0; i < n; i++) begin
      wr_t e;
      e.a = 16'hFE00 + 16'(i);
      e.d = mem[{src, 8'(i)}];
      exp_q.push_back(e);
    end
  endtask

  task automatic compare_writes(input string tag);
    int n;
    check({tag, "_count"}, wr_q.size(), exp_q.size());
    n = (wr_q.size() < exp_q.size()) ? wr_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_addr%0d", tag, i), wr_q[i].a, exp_q[i].a);
      check($sformatf("%s_data%0d", tag, i), wr_q[i].d, exp_q[i].d);
    end
    wr_q.delete();
    exp_q.delete();
  endtask

  // Called at a negedge; returns at the negedge whose next posedge samples k.
  task automatic align(input logic [1:0] k);
    while (t_cycle != k) @(negedge clk);
  endtask

  // Drive a one-clock FF46 write; counters restart for the new transfer.
  task automatic strobe(input logic [7:0] d);
    start_wr   = 1'b1;
    start_data = d;
    busy_cnt   = 0;
    sel_cnt    = 0;
    @(negedge clk);
    start_wr   = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle_timeout"}, 32'(n < budget), 32'd1);
  endtask

  task automatic wait_writes(input string tag, input int cnt, input logic [1:0] k, input int budget);
    int n = 0;
    while (!(wr_q.size() == cnt && t_cycle == k) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_wait_timeout"}, 32'(n < budget), 32'd1);
  endtask

  initial begin
    logic [7:0] s;
    int         k;
    int         n;

    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    rst        = 1'b1;
    start_wr   = 1'b0;
    start_data = 8'h00;
    busy_cnt   = 0;
    sel_cnt    = 0;

    // Reset, then idle.
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    check("rst_addr", dma_addr, 16'h0000);
    check("rst_rd", dma_rd, 1'b0);
    check("rst_wr", dma_wr, 1'b0);
    check("rst_sel", mem_ctrl_sel, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_src", src_hi, 8'hFF);
    check("rst_data", dma_data, 8'h00);
    check("rst_no_writes", wr_q.size(), 0);

    // Basic C1 copy, strobe at t_cycle==1.
    align(2'd1);
    strobe(8'hC1);
    check("c1_busy_rise", busy, 1'b1);
    check("c1_src", src_hi, 8'hC1);
    wait_idle("c1", 2000);
    check("c1_busy_len", busy_cnt, 2 + 4 + 640);
    check("c1_sel_len", sel_cnt, 640);
    push_expected(8'hC1, 160);
    compare_writes("c1");

    // Restart with D0 during byte 50 of a C1 copy.
    @(negedge clk);
    align(2'd0);
    strobe(8'hC1);
    wait_writes("rs", 50, 2'd0, 2000);
    strobe(8'hD0);
    check("rs_sel_drop", mem_ctrl_sel, 1'b0);
    check("rs_wr_drop", dma_wr, 1'b0);
    check("rs_busy", busy, 1'b1);
    check("rs_src", src_hi, 8'hD0);
    wait_idle("rs", 2000);
    check("rs_busy_len", busy_cnt, 3 + 4 + 640);
    check("rs_sel_len", sel_cnt, 640);
    push_expected(8'hC1, 50);
    push_expected(8'hD0, 160);
    compare_writes("rs");

    // Restart coincident with the final boundary of byte 159.
    @(negedge clk);
    align(2'd2);
    strobe(8'h12);
    wait_writes("bk", 160, 2'd3, 2000);
    strobe(8'h34);
    check("bk_busy", busy, 1'b1);
    check("bk_sel", mem_ctrl_sel, 1'b0);
    wait_idle("bk", 2000);
    check("bk_busy_len", busy_cnt, 4 + 4 + 640);
    check("bk_sel_len", sel_cnt, 640);
    push_expected(8'h12, 160);
    push_expected(8'h34, 160);
    compare_writes("bk");

    // Asynchronous reset during byte 80.
    @(negedge clk);
    align(2'd3);
    strobe(8'h56);
    wait_writes("ar", 81, 2'd2, 2000);
    #1 rst = 1'b1;
    #1;
    check("ar_sel", mem_ctrl_sel, 1'b0);
    check("ar_wr", dma_wr, 1'b0);
    check("ar_rd", dma_rd, 1'b0);
    check("ar_busy", busy, 1'b0);
    check("ar_addr", dma_addr, 16'h0000);
    check("ar_src", src_hi, 8'hFF);
    repeat (2) @(negedge clk);
    rst     = 1'b0;
    sel_cnt = 0;
    repeat (700) @(negedge clk);
    check("ar_idle_busy", busy, 1'b0);
    check("ar_idle_sel", sel_cnt, 0);
    push_expected(8'h56, 81);
    compare_writes("ar");

    // Echo-range source byte.
    align(2'd0);
    strobe(8'hE3);
    check("echo_src", src_hi, map_src(8'hE3));
    n = 0;
    while (dma_rd !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("echo_rd_timeout", 32'(n < 50), 32'd1);
    check("echo_first_addr", dma_addr, {map_src(8'hE3), 8'h00});
    wait_idle("echo", 2000);
    push_expected(map_src(8'hE3), 160);
    compare_writes("echo");

    // Randomized sources and strobe phases.
    for (int r = 0; r < 3; r++) begin
      s = 8'($urandom);
      k = int'($urandom_range(0, 3));
      @(negedge clk);
      align(2'(k));
      strobe(s);
      check($sformatf("rnd%0d_src", r), src_hi, map_src(s));
      wait_idle($sformatf("rnd%0d", r), 2000);
      check($sformatf("rnd%0d_busy_len", r), busy_cnt, arm_len(k) + 4 + 640);
      check($sformatf("rnd%0d_sel_len", r), sel_cnt, 640);
      push_expected(map_src(s), 160);
      compare_writes($sformatf("rnd%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/oam_dma.md
# oam_dma

OAM DMA engine that copies 160 bytes from `{src_hi, 8'h00}` to `16'hFE00`–`16'hFE9F`, one byte per M-cycle. It sits beside the CPU address buffer and drives the DMA leg of the memory address mux. Its `mem_ctrl_sel` output selects that leg, and it reads data from the same external memory output the CPU data buffer samples. A CPU write to FF46 (`start_wr`) launches a transfer.

## Interface
Parameters:
- `XFER_LEN`, 160: bytes per transfer; index width is 8 bits.
- `DEST_BASE`, 16'hFE00: destination base address.

Ports:
- `clk`  in  1  system clock; one T-cycle per clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `t_cycle`  in  2  T-cycle phase from decode; advances 0,1,2,3,0 once per clk. A posedge sampling `t_cycle==3` is the M-cycle boundary.
- `start_wr`  in  1  single-clock strobe: CPU wrote FF46.
- `start_data`  in  8  value written to FF46 (source high byte).
- `mem_data_in`  in  8  external memory data output.
- `dma_addr`  out  16  DMA address to the memory address mux.
- `dma_data`  out  8  byte latched for the write phase.
- `dma_rd`  out  1  DMA read request.
- `dma_wr`  out  1  DMA write enable.
- `mem_ctrl_sel`  out  1  1 = DMA owns the memory bus.
- `busy`  out  1  transfer pending or active.
- `src_hi`  out  8  FF46 readback: last written source byte.

## Operation
- States: IDLE, ARM, DELAY, XFER. Registers: `state`, `src_hi`, `idx[7:0]`, `dma_data`.
- IDLE → ARM: on a posedge with `start_wr=1`.
  - Captures `src_hi <= start_data` (after echo mapping, see Configuration).
  - Sets `idx <= 0`.
- ARM → DELAY: on a posedge with `t_cycle==3`. This aligns the transfer to an M-cycle boundary.
- DELAY → XFER: one full M-cycle later, on a posedge with `t_cycle==3`.
- XFER: one byte per M-cycle, by `t_cycle` phase.
  - `t_cycle` 0,1: `dma_addr = {src_hi, idx}`, `dma_rd=1`, `dma_wr=0`.
  - Posedge with `t_cycle==1`: `dma_data <= mem_data_in`.
  - `t_cycle` 2,3: `dma_addr = DEST_BASE + idx`, `dma_rd=0`, `dma_wr=1`.
  - Posedge with `t_cycle==3`: if `idx==XFER_LEN-1`, go to IDLE; else `idx <= idx+1`.
- `start_wr` in ARM, DELAY or XFER restarts the transfer: new `src_hi`, `idx <= 0`, state ARM. The bus is released immediately. Restart wins over same-edge completion or `idx` increment.
- Output decode, combinational from the registered state and `t_cycle`:
  - `busy = (state != IDLE)`.
  - `mem_ctrl_sel = (state == XFER)`.
  - Outside XFER: `dma_rd=0`, `dma_wr=0`, `dma_addr=16'h0000`.
- `idx` never exceeds `XFER_LEN-1`. There is no wrap into FEA0+.

## Timing
- Reset values:
  - `state` IDLE, `idx` 0, `dma_data` 8'h00, `src_hi` 8'hFF.
  - `dma_addr` 16'h0000, `dma_rd`, `dma_wr`, `mem_ctrl_sel`, `busy` all 0.
- Reset mid-transfer: all outputs return to reset values asynchronously. The bus is released the same instant.
- Latency, with `start_wr` sampled at a posedge where `t_cycle==k`:
  - ARM lasts `(3-k) mod 4` clocks. If `k==3`, ARM lasts 4 clocks, because the boundary for the sampling edge itself is not taken.
  - DELAY lasts 4 clocks.
  - XFER lasts `4*XFER_LEN` = 640 clocks.
- `busy` rises on the clock edge after the `start_wr` sample. It falls on the edge that samples the last `t_cycle==3` of byte 159.
- `mem_data_in` must be valid by the posedge that samples `t_cycle==1` of each XFER M-cycle.

## Configuration
- Macro `OAM_DMA_ECHO_MAP_EN`.
- Defined: a written source byte ≥ 8'hE0 has bit 5 cleared before capture. Sources E0–FF map to C0–DF (echo RAM). `src_hi` readback shows the mapped value.
- Undefined: the written byte is used and read back unchanged.

## Test plan
- Reset, then idle 8 clocks → all outputs at reset values, `src_hi`=8'hFF.
- `start_data`=8'hC1, strobe at `t_cycle==1`:
  - `busy` stays high for 2+4+640 clocks.
  - 160 writes FE00..FE9F carry mem[C100..C19F].
  - `mem_ctrl_sel` is high only for those 640 clocks.
- Restart with 8'hD0 during byte 50 of a C1 transfer:
  - Writes stop at FE32 (byte 50 not written).
  - After ARM+DELAY, a full 160-byte copy runs from D000.
- `start_wr` coincident with the final `t_cycle==3` of byte 159 → no IDLE gap, `busy` stays 1, new transfer begins.
- `rst` asserted mid-XFER at byte 80 → `mem_ctrl_sel`/`dma_wr`/`busy` drop to 0 asynchronously. No further writes occur after release.
- With the macro defined: write 8'hE3 → `src_hi` reads 8'hC3, reads from C300. Without the macro: `src_hi` reads 8'hE3, reads from E300.
